// File: rtl/vga_fb_pkg.sv
// Shared constants, FSM state type and pixel bit-index helper for the 1bpp frame buffer.
package vga_fb_pkg;

    localparam int X_W       = 7;
    localparam int Y_W       = 7;
    localparam int ROW_SHIFT = 4;
    localparam int ADDR_W    = Y_W + ROW_SHIFT;
    localparam int CNT_W     = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MOD,
        WR,
        CLR
    } state_t;

    // MSB of each byte is the leftmost pixel of its 8-pixel group.
    function automatic logic [2:0] bit_index(input logic [2:0] x_lo);
        return 3'd7 - x_lo;
    endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Maps a pixel coordinate to its frame RAM byte address and one-hot bit mask.
module fb_addr_calc
    import vga_fb_pkg::*;
(
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        mask
);

    assign addr = {y, x[X_W-1:3]};
    assign mask = 8'(1) << bit_index(x[2:0]);

endmodule

// File: rtl/fb_pixel_writer.sv
// Frame-buffer write side: single-pixel read-modify-write plots and a full-screen clear sweep.
// Build option FB_PLOT_XOR_EN: plot_val=1 toggles the pixel instead of overwriting it.
module fb_pixel_writer
    import vga_fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              plot_valid,
    output logic              plot_ready,
    input  logic [X_W-1:0]    plot_x,
    input  logic [Y_W-1:0]    plot_y,
    input  logic              plot_val,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    input  logic [7:0]        ram_rdata,
    output logic              ram_we,
    output logic [7:0]        ram_wdata
);

    state_t              state, state_nx;
    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic                val_q;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic                accept;
    logic [ADDR_W-1:0]   pix_addr;
    logic [7:0]          pix_mask;
    logic [7:0]          new_byte;
    logic [ADDR_W-1:0]   addr_nx;
    logic                rd_en_nx, we_nx, done_nx;
    logic [7:0]          wdata_nx;

    fb_addr_calc u_addr_calc (
        .x    (x_q),
        .y    (y_q),
        .addr (pix_addr),
        .mask (pix_mask)
    );

`ifdef FB_PLOT_XOR_EN
    assign new_byte = val_q ? (ram_rdata ^ pix_mask) : ram_rdata;
`else
    assign new_byte = val_q ? (ram_rdata | pix_mask) : (ram_rdata & ~pix_mask);
`endif

    // Handshake: a plot transfers on a rising edge where plot_valid && plot_ready;
    // plot_ready is high only in IDLE (and never while rst is asserted), and a
    // simultaneous clr_req wins, leaving the plot pending.
    assign plot_ready = (state == IDLE) && !rst;
    assign busy       = (state != IDLE);
    assign accept     = (state == IDLE) && plot_valid && !clr_req;

    // RAM strobes are registered, so each state's action appears one cycle later;
    // read data requested from RD therefore arrives while in WR and is merged there.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        addr_nx  = ram_addr;
        rd_en_nx = 1'b0;
        we_nx    = 1'b0;
        wdata_nx = ram_wdata;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nx = CLR;
                    cnt_nx   = '0;
                end else if (plot_valid) begin
                    state_nx = RD;
                end
            end
            RD: begin
                addr_nx  = pix_addr;
                rd_en_nx = 1'b1;
                state_nx = MOD;
            end
            MOD: begin
                state_nx = WR;
            end
            WR: begin
                we_nx    = 1'b1;
                wdata_nx = new_byte;
                state_nx = IDLE;
            end
            CLR: begin
                // Extra counter bit marks the end of the sweep without wrapping to 0.
                if (cnt[ADDR_W]) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    we_nx    = 1'b1;
                    wdata_nx = 8'h00;
                    addr_nx  = cnt[ADDR_W-1:0];
                    cnt_nx   = cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            val_q     <= 1'b0;
            ram_addr  <= '0;
            ram_rd_en <= 1'b0;
            ram_we    <= 1'b0;
            ram_wdata <= 8'h00;
            clr_done  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ram_addr  <= addr_nx;
            ram_rd_en <= rd_en_nx;
            ram_we    <= we_nx;
            ram_wdata <= wdata_nx;
            clr_done  <= done_nx;
            if (accept) begin
                x_q   <= plot_x;
                y_q   <= plot_y;
                val_q <= plot_val;
            end
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer: sync RAM model plus a pixel-level bitmap reference.
module tb_fb_pixel_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        plot_valid;
    logic        plot_ready;
    logic [6:0]  plot_x;
    logic [6:0]  plot_y;
    logic        plot_val;
    logic        clr_req;
    logic        busy;
    logic        clr_done;
    logic [10:0] ram_addr;
    logic        ram_rd_en;
    logic [7:0]  ram_rdata;
    logic        ram_we;
    logic [7:0]  ram_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame RAM (environment) with a preload port for directed byte contents.
    logic [7:0]  mem [0:2047];
    logic        pre_we = 1'b0;
    logic [10:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    // Reference: the picture itself, one bit per pixel, indexed [row][column].
    bit pix [0:127][0:127];

    fb_pixel_writer dut (
        .clk        (clk),
        .rst        (rst),
        .plot_valid (plot_valid),
        .plot_ready (plot_ready),
        .plot_x     (plot_x),
        .plot_y     (plot_y),
        .plot_val   (plot_val),
        .clr_req    (clr_req),
        .busy       (busy),
        .clr_done   (clr_done),
        .ram_addr   (ram_addr),
        .ram_rd_en  (ram_rd_en),
        .ram_rdata  (ram_rdata),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata)
    );

    always #5 clk = ~clk;

    // Read data is garbage except in the cycle after a read strobe.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_rd_en ? mem[ram_addr] : 8'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte as seen by the display: 8 pixels of one row, leftmost pixel in the MSB.
    function automatic logic [7:0] model_byte(input int a);
        logic [7:0] b;
        int r, c;
        r = a / 16;
        c = (a % 16) * 8;
        for (int i = 0; i < 8; i++) b[7-i] = pix[r][c+i];
        return b;
    endfunction

    task automatic clear_model();
        for (int r = 0; r < 128; r++)
            for (int c = 0; c < 128; c++) pix[r][c] = 1'b0;
    endtask

    task automatic set_byte(input int a, input logic [7:0] v);
        pre_addr = 11'(a);
        pre_data = v;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
        for (int i = 0; i < 8; i++) pix[a/16][(a%16)*8+i] = v[7-i];
    endtask

    task automatic do_plot(input int x, input int y, input bit v);
        int a, waited;
        logic [7:0] exp_b;
        a = y * 16 + x / 8;
        waited = 0;
        plot_x = 7'(x);
        plot_y = 7'(y);
        plot_val = v;
        plot_valid = 1'b1;
        while (!plot_ready && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check("plot_accept_wait", 32'(waited < 3000), 32'd1);
        if (waited >= 3000) begin
            plot_valid = 1'b0;
            return;
        end
`ifdef FB_PLOT_XOR_EN
        if (v) pix[y][x] = ~pix[y][x];
`else
        pix[y][x] = v;
`endif
        exp_b = model_byte(a);
        @(negedge clk);
        plot_valid = 1'b0;
        check("plot_ready_low_1", 32'(plot_ready), 32'd0);
        check("rd_en_not_early", 32'(ram_rd_en), 32'd0);
        check("clr_done_quiet", 32'(clr_done), 32'd0);
        @(negedge clk);
        check("rd_en", 32'(ram_rd_en), 32'd1);
        check("rd_addr", 32'(ram_addr), 32'(a));
        check("plot_ready_low_2", 32'(plot_ready), 32'd0);
        @(negedge clk);
        check("we_not_early", 32'(ram_we), 32'd0);
        check("rd_en_single", 32'(ram_rd_en), 32'd0);
        check("plot_ready_low_3", 32'(plot_ready), 32'd0);
        @(negedge clk);
        check("we", 32'(ram_we), 32'd1);
        check("wr_addr", 32'(ram_addr), 32'(a));
        check("wdata", 32'(ram_wdata), 32'(exp_b));
        check("plot_ready_back", 32'(plot_ready), 32'd1);
    endtask

    task automatic run_clear();
        int writes, bad, done_cnt, rd_seen, cyc;
        writes = 0; bad = 0; done_cnt = 0; rd_seen = 0; cyc = 0;
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        check("clr_busy", 32'(busy), 32'd1);
        check("clr_ready_low", 32'(plot_ready), 32'd0);
        while (done_cnt == 0 && cyc < 2200) begin
            if (ram_we) begin
                if (ram_addr !== 11'(writes) || ram_wdata !== 8'h00) bad++;
                writes++;
            end
            if (ram_rd_en) rd_seen++;
            if (clr_done) done_cnt++;
            if (done_cnt == 0) @(negedge clk);
            cyc++;
        end
        check("clr_write_count", 32'(writes), 32'd2048);
        check("clr_bad_writes", 32'(bad), 32'd0);
        check("clr_done_seen", 32'(done_cnt), 32'd1);
        check("clr_no_reads", 32'(rd_seen), 32'd0);
        check("clr_done_ready", 32'(plot_ready), 32'd1);
        clear_model();
    endtask

    initial begin
        int wait_cyc, strobes;
        rst = 1'b1;
        plot_valid = 1'b0;
        plot_x = '0;
        plot_y = '0;
        plot_val = 1'b0;
        clr_req = 1'b0;
        clear_model();
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(plot_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_rd_en", 32'(ram_rd_en), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_wdata", 32'(ram_wdata), 32'd0);
        check("rst_clr_done", 32'(clr_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(plot_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Directed corner pixels and a clear-to-zero on a full byte.
        set_byte(0, 8'h00);
        do_plot(0, 0, 1'b1);
        check("t1_wdata_const", 32'(ram_wdata), 32'h80);
        set_byte(2047, 8'h00);
        do_plot(127, 127, 1'b1);
        check("t2_addr_const", 32'(ram_addr), 32'd2047);
        check("t2_wdata_const", 32'(ram_wdata), 32'h01);
        set_byte(49, 8'hFF);
        do_plot(10, 3, 1'b0);
`ifdef FB_PLOT_XOR_EN
        check("t3_wdata_const", 32'(ram_wdata), 32'hFF);
`else
        check("t3_wdata_const", 32'(ram_wdata), 32'hDF);
`endif

        // Clear wins over a simultaneous plot, which is then taken afterwards.
        plot_x = 7'd64;
        plot_y = 7'd64;
        plot_val = 1'b1;
        plot_valid = 1'b1;
        run_clear();
        do_plot(64, 64, 1'b1);

        // Same pixel plotted twice.
        set_byte(0, 8'h00);
        do_plot(5, 0, 1'b1);
        check("t6_first_const", 32'(ram_wdata), 32'h04);
        do_plot(5, 0, 1'b1);
`ifdef FB_PLOT_XOR_EN
        check("t6_second_const", 32'(ram_wdata), 32'h00);
`else
        check("t6_second_const", 32'(ram_wdata), 32'h04);
`endif

        // Random plots on a freshly cleared screen, including repeated bytes.
        run_clear();
        @(negedge clk);
        check("clr_done_single", 32'(clr_done), 32'd0);
        for (int i = 0; i < 24; i++) begin
            int rx, ry;
            rx = $urandom_range(0, 127);
            ry = (i % 3 == 0) ? 0 : $urandom_range(0, 127);
            do_plot(rx, ry, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a clear sweep aborts it.
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        wait_cyc = 0;
        while (!(ram_we && ram_addr == 11'd1000) && wait_cyc < 1100) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("t5_reach_1000", 32'(wait_cyc < 1100), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_we_off", 32'(ram_we), 32'd0);
        check("t5_busy_off", 32'(busy), 32'd0);
        check("t5_addr_zero", 32'(ram_addr), 32'd0);
        check("t5_ready_in_rst", 32'(plot_ready), 32'd0);
        rst = 1'b0;
        strobes = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (ram_we || ram_rd_en || clr_done || busy) strobes++;
        end
        check("t5_no_resume", 32'(strobes), 32'd0);
        check("t5_ready", 32'(plot_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
